// File: rtl/regfile_arb_pkg.sv
// Shared types and defaults for the two-requester register-file arbiter.
package regfile_arb_pkg;

   localparam int unsigned DEF_ADDR_W   = 5;
   localparam int unsigned DEF_DATA_W   = 32;
   localparam int unsigned DEF_NUM_REGS = 32;

   typedef enum logic {
      CLEAR = 1'b0,
      SERVE = 1'b1
   } state_t;

   // Round-robin pointer: names the requester that wins a tie.
   localparam logic PTR_A = 1'b0;
   localparam logic PTR_B = 1'b1;

   function automatic logic next_ptr(input logic [1:0] grant, input logic ptr);
      if (grant[0]) return PTR_B;
      if (grant[1]) return PTR_A;
      return ptr;
   endfunction

endpackage

// File: rtl/regfile_arbiter_if.sv
// Request/response and register-file port bundle for regfile_arbiter.
interface regfile_arbiter_if
   import regfile_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) ();

   logic              ReqValidA, ReqValidB;
   logic              ReqReadyA, ReqReadyB;
   logic              ReqWriteA, ReqWriteB;
   logic [ADDR_W-1:0] ReqAddr1A, ReqAddr1B;
   logic [ADDR_W-1:0] ReqAddr2A, ReqAddr2B;
   logic [DATA_W-1:0] ReqDataA,  ReqDataB;

   logic              RspValidA, RspValidB;
   logic [DATA_W-1:0] RspData1A, RspData2A;
   logic [DATA_W-1:0] RspData1B, RspData2B;

   logic [ADDR_W-1:0] ReadRegister1, ReadRegister2, WriteRegister;
   logic [DATA_W-1:0] WriteData;
   logic              RegWrite;
   logic [DATA_W-1:0] ReadData1, ReadData2;

   logic              Busy;

   modport slave (
      input  ReqValidA, ReqValidB, ReqWriteA, ReqWriteB,
      input  ReqAddr1A, ReqAddr1B, ReqAddr2A, ReqAddr2B, ReqDataA, ReqDataB,
      output ReqReadyA, ReqReadyB,
      output RspValidA, RspValidB, RspData1A, RspData2A, RspData1B, RspData2B,
      output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
      input  ReadData1, ReadData2,
      output Busy
   );

   modport master (
      output ReqValidA, ReqValidB, ReqWriteA, ReqWriteB,
      output ReqAddr1A, ReqAddr1B, ReqAddr2A, ReqAddr2B, ReqDataA, ReqDataB,
      input  ReqReadyA, ReqReadyB,
      input  RspValidA, RspValidB, RspData1A, RspData2A, RspData1B, RspData2B,
      input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
      output ReadData1, ReadData2,
      input  Busy
   );

endinterface

// File: rtl/regfile_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; bit 0 is requester A, bit 1 is requester B.
module rr_arb2
   import regfile_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      unique case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (ptr == PTR_A) ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates two requesters onto one register file; clears all registers after reset.
module regfile_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned NUM_REGS = DEF_NUM_REGS
) (
   input  logic        Clk,
   input  logic        ResetN,
   regfile_arbiter_if.slave bus
);

   localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

   state_t            state;
   logic [ADDR_W-1:0] counter;
   logic              ptr;
   logic              rsp_valid_a, rsp_valid_b;
   logic [DATA_W-1:0] rsp_data1_a, rsp_data2_a, rsp_data1_b, rsp_data2_b;

   logic [1:0]        req;
   logic [1:0]        grant;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr1, sel_addr2;
   logic [DATA_W-1:0] sel_data;

   logic [ADDR_W-1:0] read_reg1, read_reg2, write_reg;
   logic [DATA_W-1:0] write_data;
   logic              reg_write;

   assign req = {bus.ReqValidB, bus.ReqValidA} & {2{state == SERVE}};

   rr_arb2 u_rr_arb2 (
      .req   (req),
      .ptr   (ptr),
      .grant (grant)
   );

   // Mux the granted requester's command.
   always_comb begin
      sel_write = 1'b0;
      sel_addr1 = '0;
      sel_addr2 = '0;
      sel_data  = '0;
      if (grant[0]) begin
         sel_write = bus.ReqWriteA;
         sel_addr1 = bus.ReqAddr1A;
         sel_addr2 = bus.ReqAddr2A;
         sel_data  = bus.ReqDataA;
      end else if (grant[1]) begin
         sel_write = bus.ReqWriteB;
         sel_addr1 = bus.ReqAddr1B;
         sel_addr2 = bus.ReqAddr2B;
         sel_data  = bus.ReqDataB;
      end
   end

   // Register-file port drive; RegWrite is gated by ResetN so nothing is written while held in reset.
   always_comb begin
      read_reg1  = '0;
      read_reg2  = '0;
      write_reg  = '0;
      write_data = '0;
      reg_write  = 1'b0;
      if (state == CLEAR) begin
         write_reg = counter;
         reg_write = ResetN;
      end else if (grant != 2'b00) begin
         if (sel_write) begin
            write_reg  = sel_addr1;
            write_data = sel_data;
            reg_write  = 1'b1;
         end else begin
            read_reg1 = sel_addr1;
            read_reg2 = sel_addr2;
         end
      end
   end

   // Sequencer: clear sweep, then serve; read data captured at the grant edge.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state       <= CLEAR;
         counter     <= '0;
         ptr         <= PTR_A;
         rsp_valid_a <= 1'b0;
         rsp_valid_b <= 1'b0;
         rsp_data1_a <= '0;
         rsp_data2_a <= '0;
         rsp_data1_b <= '0;
         rsp_data2_b <= '0;
      end else begin
         rsp_valid_a <= 1'b0;
         rsp_valid_b <= 1'b0;
         unique case (state)
            CLEAR: begin
               if (counter == LAST_REG) begin
                  state   <= SERVE;
                  counter <= '0;
               end else begin
                  counter <= counter + ADDR_W'(1);
               end
            end
            SERVE: begin
               ptr <= next_ptr(grant, ptr);
               if (!sel_write && grant[0]) begin
                  rsp_valid_a <= 1'b1;
                  rsp_data1_a <= bus.ReadData1;
                  rsp_data2_a <= bus.ReadData2;
               end
               if (!sel_write && grant[1]) begin
                  rsp_valid_b <= 1'b1;
                  rsp_data1_b <= bus.ReadData1;
                  rsp_data2_b <= bus.ReadData2;
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

   assign bus.ReqReadyA     = grant[0];
   assign bus.ReqReadyB     = grant[1];
   assign bus.RspValidA     = rsp_valid_a;
   assign bus.RspValidB     = rsp_valid_b;
   assign bus.RspData1A     = rsp_data1_a;
   assign bus.RspData2A     = rsp_data2_a;
   assign bus.RspData1B     = rsp_data1_b;
   assign bus.RspData2B     = rsp_data2_b;
   assign bus.ReadRegister1 = read_reg1;
   assign bus.ReadRegister2 = read_reg2;
   assign bus.WriteRegister = write_reg;
   assign bus.WriteData     = write_data;
   assign bus.RegWrite      = reg_write;
   assign bus.Busy          = (state == CLEAR);

endmodule
